// File: rtl/matrix_xform_ctrl.sv
// Sequencer for one matrix transform command: latches the command, loads coefficients
// (with a ROM fetch for rotations), then runs load/multiply/divide/write-back per vertex.
module matrix_xform_ctrl #(
  parameter int unsigned MAX_PTS = 4,
  parameter int unsigned IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         cmd,
  input  logic [IDX_W-1:0]   num_pts,
  input  logic [IDX_W-1:0]   sel_pt,
  input  logic [2:0]         rot_in,
  input  logic signed [15:0] mat_res_x,
  input  logic signed [15:0] mat_res_y,
  output logic               trans_one,
  output logic               trans_all,
  output logic               scl_cmd,
  output logic               rotl_cmd,
  output logic               rotr_cmd,
  output logic [2:0]         rot_amt,
  output logic               get_rotl_coeff,
  output logic               get_rotr_coeff,
  output logic               ld_trans_coeff,
  output logic               ld_scl_coeff,
  output logic               ld_rot_coeff,
  output logic               ld_point,
  output logic [IDX_W-1:0]   point_cnt,
  output logic               do_mult,
  output logic               do_div,
  output logic               wr_point,
  output logic [IDX_W-1:0]   wr_idx,
  output logic signed [15:0] wr_x,
  output logic signed [15:0] wr_y,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [3:0] {
    StIdle, StGetCoeff, StRomWait, StLdCoeff, StLdPt, StMult, StDiv, StWb, StDone
  } state_e;

  localparam logic [IDX_W-1:0] MaxPts = IDX_W'(MAX_PTS);
  localparam logic [IDX_W-1:0] OnePt  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [4:0]       flags_q, flags_d;   // bit i set for cmd code i
  logic [2:0]       rot_q, rot_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] pt_q, pt_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;       // vertices still to process, including current

  logic cmd_legal, cmd_is_rot;

  always_comb begin
    cmd_legal  = (cmd <= 3'd4) && !((cmd == 3'd0) && (sel_pt >= MaxPts));
    cmd_is_rot = (cmd == 3'd3) || (cmd == 3'd4);
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    rot_d   = rot_q;
    err_d   = err_q;
    pt_d    = pt_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          rot_d = rot_in;
          if (!cmd_legal) begin
            flags_d = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            flags_d = 5'b00001 << cmd;
            err_d   = 1'b0;
            pt_d    = (cmd == 3'd0) ? sel_pt : '0;
            cnt_d   = (cmd == 3'd0) ? OnePt : ((num_pts > MaxPts) ? MaxPts : num_pts);
            state_d = cmd_is_rot ? StGetCoeff : StLdCoeff;
          end
        end
      end
      StGetCoeff: state_d = StRomWait;
      StRomWait:  state_d = StLdCoeff;
      StLdCoeff:  state_d = (cnt_q == '0) ? StDone : StLdPt;
      StLdPt:     state_d = StMult;
      StMult:     state_d = StDiv;
      StDiv:      state_d = StWb;
      StWb: begin
        if (cnt_q > OnePt) begin
          cnt_d   = cnt_q - OnePt;
          pt_d    = pt_q + OnePt;
          state_d = StLdPt;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        flags_d = '0;
        rot_d   = '0;
        err_d   = 1'b0;
        pt_d    = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      flags_q <= '0;
      rot_q   <= '0;
      err_q   <= 1'b0;
      pt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      rot_q   <= rot_d;
      err_q   <= err_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    trans_one      = flags_q[0];
    trans_all      = flags_q[1];
    scl_cmd        = flags_q[2];
    rotl_cmd       = flags_q[3];
    rotr_cmd       = flags_q[4];
    rot_amt        = rot_q;
    get_rotl_coeff = (state_q == StGetCoeff) && flags_q[3];
    get_rotr_coeff = (state_q == StGetCoeff) && flags_q[4];
    ld_trans_coeff = (state_q == StLdCoeff) && (flags_q[0] || flags_q[1]);
    ld_scl_coeff   = (state_q == StLdCoeff) && flags_q[2];
    ld_rot_coeff   = (state_q == StLdCoeff) && (flags_q[3] || flags_q[4]);
    ld_point       = (state_q == StLdPt);
    point_cnt      = pt_q;
    do_mult        = (state_q == StMult);
    do_div         = (state_q == StDiv);
    wr_point       = (state_q == StWb);
    wr_idx         = wr_point ? pt_q : '0;
    wr_x           = wr_point ? mat_res_x : '0;
    wr_y           = wr_point ? mat_res_y : '0;
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    err            = (state_q == StDone) && err_q;
  end

endmodule

// File: tb/tb_matrix_xform_ctrl.sv
// Bench for matrix_xform_ctrl: directed and random commands checked cycle by cycle against
// a schedule model derived from command type, vertex count and latency rules.
module tb_matrix_xform_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [2:0]         cmd;
  logic [2:0]         num_pts;
  logic [2:0]         sel_pt;
  logic [2:0]         rot_in;
  logic signed [15:0] mat_res_x;
  logic signed [15:0] mat_res_y;
  logic trans_one, trans_all, scl_cmd, rotl_cmd, rotr_cmd;
  logic [2:0] rot_amt;
  logic get_rotl_coeff, get_rotr_coeff, ld_trans_coeff, ld_scl_coeff, ld_rot_coeff;
  logic ld_point, do_mult, do_div, wr_point, busy, done, err;
  logic [2:0] point_cnt, wr_idx;
  logic signed [15:0] wr_x, wr_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_xform_ctrl #(.MAX_PTS(4), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .num_pts(num_pts), .sel_pt(sel_pt),
    .rot_in(rot_in), .mat_res_x(mat_res_x), .mat_res_y(mat_res_y),
    .trans_one(trans_one), .trans_all(trans_all), .scl_cmd(scl_cmd), .rotl_cmd(rotl_cmd),
    .rotr_cmd(rotr_cmd), .rot_amt(rot_amt), .get_rotl_coeff(get_rotl_coeff),
    .get_rotr_coeff(get_rotr_coeff), .ld_trans_coeff(ld_trans_coeff),
    .ld_scl_coeff(ld_scl_coeff), .ld_rot_coeff(ld_rot_coeff), .ld_point(ld_point),
    .point_cnt(point_cnt), .do_mult(do_mult), .do_div(do_div), .wr_point(wr_point),
    .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .busy(busy), .done(done), .err(err)
  );

  logic [57:0] all_outs;
  logic [10:0] strobes;
  logic [4:0]  flags;
  assign all_outs = {trans_one, trans_all, scl_cmd, rotl_cmd, rotr_cmd, rot_amt,
                     get_rotl_coeff, get_rotr_coeff, ld_trans_coeff, ld_scl_coeff, ld_rot_coeff,
                     ld_point, point_cnt, do_mult, do_div, wr_point, wr_idx, wr_x, wr_y,
                     busy, done, err};
  assign strobes = {get_rotl_coeff, get_rotr_coeff, ld_trans_coeff, ld_scl_coeff, ld_rot_coeff,
                    ld_point, do_mult, do_div, wr_point, done, err};
  assign flags = {rotr_cmd, rotl_cmd, scl_cmd, trans_all, trans_one};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_data();
    mat_res_x = 16'($urandom);
    mat_res_y = 16'($urandom);
  endtask

  // Issue one command at a negedge and check every cycle up to one past done.
  // abort_at > 0 pulls rst_n low in that cycle and ends the command there.
  task automatic run(input logic [2:0] c, input logic [2:0] np, input logic [2:0] sp,
                     input logic [2:0] ro, input bit poke, input int abort_at);
    bit legal, is_rot;
    int n, base, pre, last;
    logic [10:0] exp_s;
    logic [4:0]  exp_f;
    legal  = (c <= 3'd4) && !(c == 3'd0 && sp >= 3'd4);
    is_rot = (c == 3'd3) || (c == 3'd4);
    n      = (c == 3'd0) ? 1 : ((np > 3'd4) ? 4 : int'(np));
    base   = (c == 3'd0) ? int'(sp) : 0;
    pre    = is_rot ? 3 : 1;
    last   = legal ? pre + 1 + 4 * n : 1;
    exp_f  = legal ? (5'b00001 << c) : 5'b0;
    cmd = c; num_pts = np; sel_pt = sp; rot_in = ro; start = 1'b1;
    randomize_data();
    @(negedge clk);
    for (int k = 1; k <= last; k++) begin
      int ph, v, p;
      bit in_pt;
      ph    = k - pre - 1;
      in_pt = legal && (k > pre) && (k < last);
      v     = in_pt ? ph / 4 : 0;
      p     = in_pt ? ph % 4 : -1;
      exp_s = '0;
      if (legal) begin
        exp_s[10] = (c == 3'd3) && (k == 1);
        exp_s[9]  = (c == 3'd4) && (k == 1);
        exp_s[8]  = (c <= 3'd1) && (k == pre);
        exp_s[7]  = (c == 3'd2) && (k == pre);
        exp_s[6]  = is_rot && (k == pre);
        exp_s[5]  = (p == 0);
        exp_s[4]  = (p == 1);
        exp_s[3]  = (p == 2);
        exp_s[2]  = (p == 3);
        exp_s[1]  = (k == last);
      end else begin
        exp_s[1] = 1'b1;
        exp_s[0] = 1'b1;
      end
      chk("strobes", 64'(strobes), 64'(exp_s));
      chk("busy", 64'(busy), 64'(1));
      chk("flags", 64'(flags), 64'(exp_f));
      if (legal) chk("rot_amt", 64'(rot_amt), 64'(ro));
      if (p >= 0) chk("point_cnt", 64'(point_cnt), 64'(base + v));
      if (p == 3) begin
        chk("wr_idx", 64'(wr_idx), 64'(base + v));
        chk("wr_x", 64'(wr_x), 64'(mat_res_x));
        chk("wr_y", 64'(wr_y), 64'(mat_res_y));
      end
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1 chk("abort_outs", 64'(all_outs), 64'(0));
        @(negedge clk);
        chk("abort_hold", 64'(all_outs), 64'(0));
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      // A start during busy must not disturb the running command.
      start   = poke && (k == 1);
      cmd     = 3'($urandom);
      num_pts = 3'($urandom);
      sel_pt  = 3'($urandom);
      rot_in  = 3'($urandom);
      randomize_data();
      @(negedge clk);
    end
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_strobes", 64'(strobes), 64'(0));
    chk("idle_flags", 64'(flags), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd = '0; num_pts = '0; sel_pt = '0; rot_in = '0;
    mat_res_x = 16'h1234; mat_res_y = 16'h5678;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'(all_outs), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 64'(all_outs), 64'(0));

    run(3'd1, 3'd4, 3'd0, 3'd0, 1'b0, 0);  // trans_all, 4 points
    run(3'd3, 3'd2, 3'd0, 3'd3, 1'b0, 0);  // rotl by 3, 2 points
    run(3'd0, 3'd0, 3'd2, 3'd0, 1'b0, 0);  // trans_one on vertex 2
    run(3'd6, 3'd3, 3'd1, 3'd0, 1'b0, 0);  // illegal cmd
    run(3'd0, 3'd2, 3'd5, 3'd0, 1'b0, 0);  // trans_one out of range
    run(3'd1, 3'd3, 3'd0, 3'd0, 1'b1, 0);  // start during busy
    run(3'd2, 3'd7, 3'd0, 3'd0, 1'b0, 0);  // scl clamps to 4
    run(3'd2, 3'd0, 3'd0, 3'd0, 1'b0, 0);  // scl with no vertices
    run(3'd4, 3'd1, 3'd0, 3'd5, 1'b1, 0);  // rotr
    run(3'd1, 3'd4, 3'd0, 3'd0, 1'b0, 7);  // reset in MULT of point 1
    @(negedge clk);
    run(3'd1, 3'd4, 3'd0, 3'd0, 1'b0, 0);  // clean rerun after abort

    for (int i = 0; i < 30; i++) begin
      run(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 0);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
